// File: rtl/shift_right.sv
// shift_right: registered right shifter, arithmetic or logical, one-cycle latency.
// Define SHIFT_RIGHT_STICKY_EN to add a sticky output (OR of shifted-out bits).
module shift_right #(
  parameter int WIDTH = 4,
  parameter int SHW = $clog2(WIDTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in,
  input  logic [SHW-1:0]          shamt,
  input  logic                    arith,
  output logic signed [WIDTH-1:0] out,
  output logic                    out_valid
`ifdef SHIFT_RIGHT_STICKY_EN
  ,
  output logic                    sticky
`endif
);
  logic signed [WIDTH-1:0] out_q, out_d;
  logic valid_q;
  // Oversized shamt naturally yields all-sign or all-zero fill.
  assign out_d = in_valid ? (arith ? (in >>> shamt) : (in >> shamt)) : out_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= in_valid;
    end
  assign out = out_q;
  assign out_valid = valid_q;
`ifdef SHIFT_RIGHT_STICKY_EN
  logic sticky_q, sticky_d;
  // The mask covers every bit position that drops off the right end.
  assign sticky_d = in_valid ? |(in & ~({WIDTH{1'b1}} << shamt)) : sticky_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  assign sticky = sticky_q;
`endif
endmodule

// File: tb/tb_shift_right.sv
// tb_shift_right: randomized and directed checks of shift_right (WIDTH=4) against an arithmetic model.
module tb_shift_right;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic signed [3:0] din = '0;
  logic [2:0] shamt = '0;
  logic arith = 1'b0;
  logic signed [3:0] dout;
  logic out_valid;
  int tests = 0;
  int fails = 0;
`ifdef SHIFT_RIGHT_STICKY_EN
  logic sticky;
`endif

  shift_right #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .shamt(shamt), .arith(arith),
    .out(dout), .out_valid(out_valid)
`ifdef SHIFT_RIGHT_STICKY_EN
    , .sticky(sticky)
`endif
  );

  always #5 clk = ~clk;

  // Shift as division by 2**sh, floored; signed value when arithmetic.
  function automatic logic [3:0] model(input logic [3:0] a, input int sh, input bit ar);
    int v, d, q;
    v = (ar && a[3]) ? int'(a) - 16 : int'(a);
    d = 1 << sh;
    q = v / d;
    if (v < 0 && v % d != 0) q = q - 1;
    return q[3:0];
  endfunction

  function automatic bit smodel(input logic [3:0] a, input int sh);
    return (int'(a) % (1 << sh)) != 0;
  endfunction

  task automatic drive(input bit v, input logic [3:0] a, input logic [2:0] sh, input bit ar);
    @(negedge clk);
    in_valid = v;
    din = a;
    shamt = sh;
    arith = ar;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if (dout !== 4'b0000 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset: out=%b valid=%b, expected 0000/0", dout, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input string name, input logic [3:0] a, input logic [2:0] sh, input bit ar);
    logic [3:0] e;
    e = model(a, int'(sh), ar);
    drive(1'b1, a, sh, ar);
    @(posedge clk);
    #1;
    tests++;
    if (dout !== e || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s: in=%b sh=%0d ar=%0b out=%b valid=%b, expected %b/1", name, a, sh, ar, dout, out_valid, e);
    end
`ifdef SHIFT_RIGHT_STICKY_EN
    tests++;
    if (sticky !== smodel(a, int'(sh))) begin
      fails++;
      $display("FAIL %s_sticky: in=%b sh=%0d sticky=%b, expected %b", name, a, sh, sticky, smodel(a, int'(sh)));
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [3:0] ins [5] = '{4'b1101, 4'b0101, 4'b0010, 4'b1111, 4'b0000};
    logic [3:0] exp [5] = '{4'b1110, 4'b0010, 4'b0001, 4'b1111, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ins[i], 3'd1, 1'b1);
      @(posedge clk);
      #1;
      tests++;
      if (dout !== exp[i] || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL b2b[%0d]: out=%b valid=%b, expected %b/1", i, dout, out_valid, exp[i]);
      end
    end
  endtask

  task automatic test_logical();
    run_vec("log_1101_1", 4'b1101, 3'd1, 1'b0);
    run_vec("log_1000_3", 4'b1000, 3'd3, 1'b0);
  endtask

  task automatic test_boundary();
    run_vec("ar_1000_4", 4'b1000, 3'd4, 1'b1);
    run_vec("ar_1000_7", 4'b1000, 3'd7, 1'b1);
    run_vec("ar_0111_4", 4'b0111, 3'd4, 1'b1);
    run_vec("log_1011_5", 4'b1011, 3'd5, 1'b0);
    run_vec("sh0_1010", 4'b1010, 3'd0, 1'b1);
    run_vec("sh0_0110", 4'b0110, 3'd0, 1'b0);
  endtask

  task automatic test_sticky();
    run_vec("st_0101_1", 4'b0101, 3'd1, 1'b0);
    run_vec("st_0100_2", 4'b0100, 3'd2, 1'b1);
    run_vec("st_0001_4", 4'b0001, 3'd4, 1'b0);
  endtask

  task automatic test_hold();
    run_vec("hold_load", 4'b1101, 3'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'($urandom), 3'($urandom), 1'($urandom));
      @(posedge clk);
      #1;
      tests++;
      if (dout !== 4'b1110 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL hold[%0d]: out=%b valid=%b, expected 1110/0", i, dout, out_valid);
      end
    end
  endtask

  task automatic test_async_reset();
    run_vec("pre_rst", 4'b1101, 3'd1, 1'b1);
    #2;
    rst = 1'b1;
    in_valid = 1'b1;
    din = 4'b0110;
    #1;
    tests++;
    if (dout !== 4'b0000 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_rst: out=%b valid=%b, expected 0000/0", dout, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (dout !== 4'b0000 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_discard: out=%b valid=%b, expected 0000/0", dout, out_valid);
    end
    run_vec("post_rst", 4'b1001, 3'd2, 1'b1);
  endtask

  task automatic test_random();
    logic [3:0] exp_out;
    bit exp_v;
`ifdef SHIFT_RIGHT_STICKY_EN
    bit exp_s;
    exp_s = sticky;
`endif
    exp_out = dout;
    for (int i = 0; i < 300; i++) begin
      bit v, ar;
      logic [3:0] a;
      logic [2:0] sh;
      v = ($urandom_range(0, 3) != 0);
      a = 4'($urandom);
      sh = 3'($urandom);
      ar = 1'($urandom);
      drive(v, a, sh, ar);
      if (v) begin
        exp_out = model(a, int'(sh), ar);
`ifdef SHIFT_RIGHT_STICKY_EN
        exp_s = smodel(a, int'(sh));
`endif
      end
      exp_v = v;
      @(posedge clk);
      #1;
      tests++;
      if (dout !== exp_out || out_valid !== exp_v) begin
        fails++;
        $display("FAIL rand[%0d]: in=%b sh=%0d ar=%0b v=%0b out=%b valid=%b, expected %b/%0b",
                 i, a, sh, ar, v, dout, out_valid, exp_out, exp_v);
      end
`ifdef SHIFT_RIGHT_STICKY_EN
      tests++;
      if (sticky !== exp_s) begin
        fails++;
        $display("FAIL rand_sticky[%0d]: sticky=%b, expected %b", i, sticky, exp_s);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_logical();
    test_boundary();
    test_sticky();
    test_hold();
    test_async_reset();
    test_random();
    drive(1'b0, 4'b0000, 3'd0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/shift_right.md
SHIFT_RIGHT -- requirements
Module: shift_right

Interface
REQ-001 Parameter WIDTH, default 4: operand and result width in bits; legal values are 2 to 64.
REQ-002 Parameter SHW, default $clog2(WIDTH)+1: shift-amount width, wide enough to encode the value WIDTH.
REQ-003 Ports (clock and reset first):
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  qualifies in, shamt and arith for capture this cycle.
- in  input  WIDTH  operand, two's-complement signed.
- shamt  input  SHW  right-shift distance, unsigned.
- arith  input  1  1 = arithmetic shift (sign fill), 0 = logical shift (zero fill).
- out  output  WIDTH  registered shift result, signed.
- out_valid  output  1  high for exactly one cycle per accepted operand.

Function
REQ-004 On a rising clk edge with in_valid=1, out SHALL load in shifted right by shamt bit positions.
- Vacated MSBs are filled with in[WIDTH-1] when arith=1.
- Vacated MSBs are filled with 0 when arith=0.
REQ-005 Latency SHALL be exactly 1 cycle: out_valid SHALL be 1 in the cycle after in_valid=1 is sampled, and 0 otherwise.
REQ-006 With in_valid=0, out SHALL hold its previous value and out_valid SHALL go to 0.
REQ-007 Back-to-back operation: in_valid=1 on consecutive cycles SHALL produce one result per cycle with no bubbles.
REQ-008 shamt=0 SHALL pass in through unchanged.
REQ-009 When shamt>=WIDTH, out SHALL be all copies of in[WIDTH-1] if arith=1, and all zeros if arith=0.
REQ-010 The block SHALL have no backpressure; every in_valid=1 cycle is accepted.
REQ-011 Inputs SHALL be sampled only at the clk edge; out SHALL NOT have a combinational path from any input.

Reset
REQ-012 While rst=1, out SHALL be 0 and out_valid SHALL be 0, asynchronously and independent of clk.
REQ-013 Assertion of rst in the same cycle as in_valid=1 SHALL discard that operand, and no result SHALL appear after rst is released.
REQ-014 After rst is deasserted, the first capture SHALL occur at the first rising clk edge with in_valid=1.

Configuration
REQ-015 Macro SHIFT_RIGHT_STICKY_EN controls a sticky output.
- When defined, the block SHALL add output port sticky (1 bit, registered alongside out).
- sticky SHALL equal the OR of all bits shifted out of in.
- For shamt>=WIDTH, sticky is the OR of all of in.
- sticky resets to 0 and holds with out.
REQ-016 When SHIFT_RIGHT_STICKY_EN is undefined, the sticky port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification (WIDTH=4)
REQ-017 Arithmetic shift by 1: in=1101, 0101, 0010, 1111, 0000, each with shamt=1, arith=1, in_valid=1 on consecutive cycles SHALL give out=1110, 0010, 0001, 1111, 0000, each one cycle later with out_valid=1.
REQ-018 Logical shift: in=1101, shamt=1, arith=0 SHALL give out=0110; in=1000, shamt=3, arith=0 SHALL give out=0001.
REQ-019 Boundary: in=1000 with shamt=4 and shamt=7, arith=1, SHALL give 1111; in=0111, shamt=4, arith=1 SHALL give 0000; shamt=0 SHALL return in.
REQ-020 Hold and valid: a result of 1110 followed by in_valid=0 for 3 cycles SHALL keep out=1110 with out_valid=0 after the first cycle.
REQ-021 Reset: rst asserted mid-stream between clock edges SHALL immediately force out=0000 and out_valid=0; in_valid=1 coincident with rst SHALL produce no result.
REQ-022 With SHIFT_RIGHT_STICKY_EN defined:
- in=0101, shamt=1 SHALL give sticky=1.
- in=0100, shamt=2 SHALL give sticky=0.
- in=0001, shamt=4 SHALL give sticky=1.
